// File: rtl/id_stage_pipe.sv
// id_stage_pipe -- instruction-decode stage with integrated ID/EX register.
//
// Reads a 2R/1W register file, extends the 16-bit immediate, detects
// load-use hazards (stall + bubble) and registers every decode result into
// an ID/EX bank with a valid bit. A branch flush kills the instruction in ID.
//
// Parameters:
//   DATA_W (>=32)  datapath width; immediates extend to DATA_W
//   NREGS  (<=32)  architectural registers; r0 and addresses >= NREGS read 0
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   if_valid, instr, pc_plus4_in  instruction from IF/ID
//   id_mem_read, imm_mode       decoded control for the instruction in ID
//   flush                       branch taken: kill the instruction in ID
//   wb_reg_write/_reg/_data     write-back port
//   stall                       combinational load-use hazard (hold IF/ID, PC)
//   idex_*                      registered decode results
//
// Build option: ID_BYPASS_EN -- when defined, a write-back to the register
// being read in the same cycle is forwarded to the read port (write-through).
// When undefined the read returns the pre-write value.

module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_plus4_in,
  input  logic              id_mem_read,
  input  logic [1:0]        imm_mode,
  input  logic              flush,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              stall,
  output logic              idex_valid,
  output logic              idex_mem_read,
  output logic [DATA_W-1:0] idex_rd1,
  output logic [DATA_W-1:0] idex_rd2,
  output logic [DATA_W-1:0] idex_imm,
  output logic [4:0]        idex_rs,
  output logic [4:0]        idex_rt,
  output logic [4:0]        idex_rd,
  output logic [DATA_W-1:0] idex_pc_plus4
);

  // 6 bits so the range check stays meaningful even when NREGS == 32.
  localparam logic [5:0] NREGS_LIM = 6'(NREGS);

  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  assign rs  = instr[25:21];
  assign rt  = instr[20:16];
  assign rd  = instr[15:11];
  assign imm = instr[15:0];

  // ---------------------------------------------------------------------
  // Register file. Cleared on reset, so it is built from flops.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] rf_reg [NREGS];
  logic              wb_en;

  assign wb_en = wb_reg_write && (wb_write_reg != 5'd0) &&
                 ({1'b0, wb_write_reg} < NREGS_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_reg[i] <= '0;
    end else if (wb_en) begin
      rf_reg[wb_write_reg] <= wb_write_data;
    end
  end

  // Two identical read ports: port 0 reads rs, port 1 reads rt.
  logic [4:0]        rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = rs;
  assign rd_addr[1] = rt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      logic              in_range;
      logic [DATA_W-1:0] stored;

      assign in_range = (rd_addr[gi] != 5'd0) && ({1'b0, rd_addr[gi]} < NREGS_LIM);
      assign stored   = in_range ? rf_reg[rd_addr[gi]] : '0;

`ifdef ID_BYPASS_EN
      // in_range already excludes r0 and out-of-range addresses, which the
      // write port ignores as well.
      assign rd_data[gi] = (in_range && wb_reg_write && (wb_write_reg == rd_addr[gi]))
                           ? wb_write_data : stored;
`else
      assign rd_data[gi] = stored;
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Immediate extension. Size casts of signed operands sign-extend.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] imm_ext;

  always_comb begin
    imm_ext = DATA_W'($signed(imm));
    case (imm_mode)
      2'b01:   imm_ext = DATA_W'(imm);
      2'b10:   imm_ext = DATA_W'($signed({imm, 16'h0000}));
      default: imm_ext = DATA_W'($signed(imm));
    endcase
  end

  // ---------------------------------------------------------------------
  // Load-use hazard: the load in EX cannot forward in time for ID's use.
  // Depends only on ID/EX register contents and instr, never on itself.
  // ---------------------------------------------------------------------
  assign stall = if_valid && idex_valid && idex_mem_read && (idex_rt != 5'd0) &&
                 ((idex_rt == rs) || (idex_rt == rt));

  // ---------------------------------------------------------------------
  // ID/EX register. Flush and stall both insert a bubble; payload fields
  // hold on a bubble since they are don't-care while valid is 0.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_valid    <= 1'b0;
      idex_mem_read <= 1'b0;
      idex_rd1      <= '0;
      idex_rd2      <= '0;
      idex_imm      <= '0;
      idex_rs       <= '0;
      idex_rt       <= '0;
      idex_rd       <= '0;
      idex_pc_plus4 <= '0;
    end else if (flush || stall) begin
      idex_valid    <= 1'b0;
      idex_mem_read <= 1'b0;
    end else begin
      idex_valid    <= if_valid;
      idex_mem_read <= if_valid && id_mem_read;
      idex_rd1      <= rd_data[0];
      idex_rd2      <= rd_data[1];
      idex_imm      <= imm_ext;
      idex_rs       <= rs;
      idex_rt       <= rt;
      idex_rd       <= rd;
      idex_pc_plus4 <= pc_plus4_in;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Testbench for id_stage_pipe: directed steps from the test plan followed by
// a randomized run, all checked against a behavioural model of the stage.
module tb_id_stage_pipe;

  localparam int DW = 32;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_valid = 1'b0;
  logic [31:0]   instr = '0;
  logic [DW-1:0] pc_plus4_in = '0;
  logic          id_mem_read = 1'b0;
  logic [1:0]    imm_mode = 2'b00;
  logic          flush = 1'b0;
  logic          wb_reg_write = 1'b0;
  logic [4:0]    wb_write_reg = '0;
  logic [DW-1:0] wb_write_data = '0;
  logic          stall;
  logic          idex_valid, idex_mem_read;
  logic [DW-1:0] idex_rd1, idex_rd2, idex_imm, idex_pc_plus4;
  logic [4:0]    idex_rs, idex_rt, idex_rd;

  id_stage_pipe #(.DATA_W(DW), .NREGS(NR)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .instr(instr),
    .pc_plus4_in(pc_plus4_in), .id_mem_read(id_mem_read), .imm_mode(imm_mode),
    .flush(flush), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .stall(stall), .idex_valid(idex_valid),
    .idex_mem_read(idex_mem_read), .idex_rd1(idex_rd1), .idex_rd2(idex_rd2),
    .idex_imm(idex_imm), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_pc_plus4(idex_pc_plus4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] m_regs [NR];
  logic          m_valid, m_mr;
  logic [DW-1:0] m_rd1, m_rd2, m_imm, m_pc;
  logic [4:0]    m_rs, m_rt, m_rd;
  logic          last_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_valid = 0; m_mr = 0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0;
    m_rs = '0; m_rt = '0; m_rd = '0;
  endtask

  function automatic logic [DW-1:0] m_read(input logic [4:0] a);
    if (a == 0 || int'(a) >= NR) return '0;
`ifdef ID_BYPASS_EN
    if (wb_reg_write && wb_write_reg == a) return wb_write_data;
`endif
    return m_regs[a];
  endfunction

  // Immediate as an integer value, then truncated to DW bits.
  function automatic logic [DW-1:0] m_ext(input logic [15:0] i16, input logic [1:0] mode);
    longint v;
    v = longint'(i16);
    if (mode == 2'b01) begin
      v = longint'(i16);
    end else if (mode == 2'b10) begin
      v = longint'(i16) * 65536;
      if (i16 >= 16'h8000) v = v - 64'sh1_0000_0000;
    end else begin
      if (i16 >= 16'h8000) v = v - 65536;
    end
    return v[DW-1:0];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(idex_valid),    64'(m_valid));
    chk({tag, ".memrd"}, 64'(idex_mem_read), 64'(m_mr));
    chk({tag, ".rd1"},   64'(idex_rd1),      64'(m_rd1));
    chk({tag, ".rd2"},   64'(idex_rd2),      64'(m_rd2));
    chk({tag, ".imm"},   64'(idex_imm),      64'(m_imm));
    chk({tag, ".rs"},    64'(idex_rs),       64'(m_rs));
    chk({tag, ".rt"},    64'(idex_rt),       64'(m_rt));
    chk({tag, ".rd"},    64'(idex_rd),       64'(m_rd));
    chk({tag, ".pc4"},   64'(idex_pc_plus4), 64'(m_pc));
  endtask

  // One clock: inputs are already driven (just after a rising edge).
  task automatic cycle(input string tag);
    logic [4:0] rs, rt;
    logic       exp_stall;
    logic [DW-1:0] r1, r2;
    rs = instr[25:21];
    rt = instr[20:16];
    @(negedge clk);
    exp_stall = if_valid && m_valid && m_mr && m_rt != 0 && (m_rt == rs || m_rt == rt);
    last_stall = stall;
    chk({tag, ".stall"}, 64'(stall), 64'(exp_stall));
    r1 = m_read(rs);
    r2 = m_read(rt);
    if (flush || exp_stall) begin
      m_valid = 0; m_mr = 0;
    end else begin
      m_valid = if_valid;
      m_mr    = if_valid && id_mem_read;
      m_rd1 = r1; m_rd2 = r2;
      m_imm = m_ext(instr[15:0], imm_mode);
      m_rs = rs; m_rt = rt; m_rd = instr[15:11];
      m_pc = pc_plus4_in;
    end
    if (wb_reg_write && wb_write_reg != 0 && int'(wb_write_reg) < NR)
      m_regs[wb_write_reg] = wb_write_data;
    @(posedge clk);
    #1;
    check_all(tag);
    $display("cyc %s: iv=%0d instr=%08h fl=%0d stall=%0d -> v=%0d mr=%0d rd1=%0h rd2=%0h imm=%0h",
             tag, if_valid, instr, flush, last_stall, idex_valid, idex_mem_read,
             idex_rd1, idex_rd2, idex_imm);
  endtask

  task automatic set_id(input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [15:0] imm, input logic mr, input logic [1:0] mode);
    if_valid    = iv;
    instr       = {6'b100011, rs, rt, imm};
    id_mem_read = mr;
    imm_mode    = mode;
    pc_plus4_in = pc_plus4_in + 4;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a, input logic [DW-1:0] d);
    wb_reg_write  = we;
    wb_write_reg  = a;
    wb_write_data = d;
  endtask

  initial begin
    model_reset();
    last_stall = 0;

    // Reset state
    #12;
    check_all("reset");
    chk("reset.stall", 64'(stall), 64'd0);
    rst = 0;
    @(posedge clk); #1;

    // Write r5 = 0x1234 through WB, nothing in ID
    set_id(0, 0, 0, 16'h0, 0, 2'b00);
    set_wb(1, 5'd5, 32'h1234);
    cycle("wb_r5");

    // Decode rs=5, rt=0, imm=FFFE sign-extended
    set_wb(0, 0, 0);
    set_id(1, 5'd5, 5'd0, 16'hFFFE, 0, 2'b00);
    cycle("dec_r5");
    chk("dec_r5.rd1_k", 64'(idex_rd1), 64'h1234);
    chk("dec_r5.rd2_k", 64'(idex_rd2), 64'h0);
    chk("dec_r5.imm_k", 64'(idex_imm), 64'hFFFF_FFFE);
    chk("dec_r5.v_k",   64'(idex_valid), 64'd1);

    // Zero and upper extension
    set_id(1, 5'd1, 5'd2, 16'h8001, 0, 2'b01);
    cycle("imm_zero");
    chk("imm_zero.k", 64'(idex_imm), 64'h0000_8001);
    set_id(1, 5'd1, 5'd2, 16'h8001, 0, 2'b10);
    cycle("imm_upper");
    chk("imm_upper.k", 64'(idex_imm), 64'h8001_0000);
    set_id(1, 5'd1, 5'd2, 16'h8001, 0, 2'b11);
    cycle("imm_mode3");
    chk("imm_mode3.k", 64'(idex_imm), 64'hFFFF_8001);

    // Load rt=7, then use of r7: one stall cycle, then issue
    set_id(1, 5'd1, 5'd7, 16'h0010, 1, 2'b00);
    cycle("load_r7");
    set_id(1, 5'd7, 5'd2, 16'h0020, 0, 2'b00);
    cycle("use_r7_a");
    chk("use_r7_a.stall_k", 64'(last_stall), 64'd1);
    chk("use_r7_a.v_k",     64'(idex_valid), 64'd0);
    cycle("use_r7_b");
    chk("use_r7_b.stall_k", 64'(last_stall), 64'd0);
    chk("use_r7_b.v_k",     64'(idex_valid), 64'd1);

    // Load with rt=0 never stalls
    set_id(1, 5'd1, 5'd0, 16'h0004, 1, 2'b00);
    cycle("load_r0");
    set_id(1, 5'd0, 5'd0, 16'h0008, 0, 2'b00);
    cycle("use_r0");
    chk("use_r0.stall_k", 64'(last_stall), 64'd0);

    // Same-cycle WB and read of r3
    set_id(0, 0, 0, 16'h0, 0, 2'b00);
    set_wb(1, 5'd3, 32'h55);
    cycle("wb_r3_old");
    set_wb(1, 5'd3, 32'hAA);
    set_id(1, 5'd3, 5'd0, 16'h0, 0, 2'b00);
    cycle("wb_r3_same");
`ifdef ID_BYPASS_EN
    chk("wb_r3_same.k", 64'(idex_rd1), 64'hAA);
`else
    chk("wb_r3_same.k", 64'(idex_rd1), 64'h55);
`endif
    set_wb(0, 0, 0);

    // Flush together with a stall condition
    set_id(1, 5'd1, 5'd9, 16'h0, 1, 2'b00);
    cycle("load_r9");
    set_id(1, 5'd9, 5'd9, 16'h0, 1, 2'b00);
    flush = 1;
    cycle("flush_stall");
    chk("flush_stall.stall_k", 64'(last_stall), 64'd1);
    chk("flush_stall.v_k",     64'(idex_valid), 64'd0);
    chk("flush_stall.mr_k",    64'(idex_mem_read), 64'd0);
    flush = 0;

    // Randomized run; IF/ID holds its instruction while stalled
    for (int n = 0; n < 300; n++) begin
      if (!last_stall || flush) begin
        set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 16'($urandom),
               1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
      end
      flush = ($urandom_range(0, 9) == 0);
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), DW'($urandom));
      cycle("rand");
    end
    flush = 0;
    set_wb(0, 0, 0);

    // Asynchronous reset in the middle of a stall
    set_id(1, 5'd1, 5'd4, 16'h0, 1, 2'b00);
    cycle("load_r4");
    set_id(1, 5'd4, 5'd0, 16'h0, 0, 2'b00);
    #2;
    rst = 1;
    #1;
    model_reset();
    check_all("midrst");
    chk("midrst.stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    set_id(1, 5'd5, 5'd3, 16'h7FFF, 0, 2'b00);
    cycle("after_rst");
    chk("after_rst.v_k",   64'(idex_valid), 64'd1);
    chk("after_rst.rd1_k", 64'(idex_rd1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
